// File: rtl/dma_w_burst_ctrl_if.sv
// Command, source-stream and engine-side signals of the write burst controller.
interface dma_w_burst_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
);
    // command / status
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  xfer_len;
    logic              busy;
    logic              done;
    logic              err;
    // source word stream
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    // engine databus / config
    logic              eng_valid;
    logic [ADDR_W-1:0] eng_addr;
    logic [DATA_W-1:0] eng_wdata;
    logic [DATA_W/8-1:0] eng_wstrb;
    logic [7:0]        eng_len;
    logic              eng_ready;
    logic              eng_dma_ready;
    logic              eng_error;

    // controller side
    modport slave (
        input  start, start_addr, xfer_len, s_valid, s_data,
               eng_ready, eng_dma_ready, eng_error,
        output busy, done, err, s_ready,
               eng_valid, eng_addr, eng_wdata, eng_wstrb, eng_len
    );

    // command issuer / source / engine side
    modport master (
        output start, start_addr, xfer_len, s_valid, s_data,
               eng_ready, eng_dma_ready, eng_error,
        input  busy, done, err, s_ready,
               eng_valid, eng_addr, eng_wdata, eng_wstrb, eng_len
    );
endinterface

// File: rtl/dma_w_burst_ctrl.sv
// Write-side burst controller: buffers the source stream in a show-ahead
// FIFO and cuts a transfer into INCR bursts (<= MAX_BEATS, no 4 KB crossing),
// presenting each burst to the engine only once all its words are buffered.
module dma_w_burst_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BEATS = 16,
    parameter int FIFO_AW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    dma_w_burst_ctrl_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
        FILL  = 3'd2,
        BURST = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t state_q, state_d;

    // ---------------- FIFO ----------------
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               rdy_en_q;   // keeps s_ready low until the first edge after reset
    logic               push, pop;

    assign bus.s_ready = rdy_en_q && (count_q != FULL_CNT);
    assign push        = bus.s_valid && bus.s_ready;
    // Pops only count in BURST; the count guard is belt-and-braces since FILL
    // already guarantees the whole burst is buffered.
    assign pop         = (state_q == BURST) && bus.eng_ready && (count_q != '0);

    // FIFO storage; contents need no reset because the pointers are flushed
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.s_data;
    end

    // FIFO pointers, occupancy and ready enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- burst control ----------------
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [8:0]        beats_q, beats_d;
    logic [8:0]        popped_q, popped_d;
    logic [ADDR_W-1:0] eng_addr_q, eng_addr_d;
    logic [7:0]        eng_len_q, eng_len_d;
    logic              eng_valid_q, eng_valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [12:0]       room_bytes;
    logic [12:0]       room_beats;
    logic [31:0]       lim;
    logic [8:0]        beats_calc;
    logic [LEN_W-1:0]  rem_next;

    // Burst size: smallest of words left, MAX_BEATS and beats to the 4 KB edge
    always_comb begin
        room_bytes = 13'h1000 - {1'b0, cur_addr_q[11:0]};
        room_beats = room_bytes >> BSH;
        lim        = MAX_BEATS;
        if (32'(remaining_q) < lim) lim = 32'(remaining_q);
        if (32'(room_beats) < lim)  lim = 32'(room_beats);
        beats_calc = 9'(lim);
    end

    // Controller state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            beats_q     <= '0;
            popped_q    <= '0;
            eng_addr_q  <= '0;
            eng_len_q   <= '0;
            eng_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            beats_q     <= beats_d;
            popped_q    <= popped_d;
            eng_addr_q  <= eng_addr_d;
            eng_len_q   <= eng_len_d;
            eng_valid_q <= eng_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state and register updates
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        beats_d     = beats_q;
        popped_d    = popped_q;
        eng_addr_d  = eng_addr_q;
        eng_len_d   = eng_len_q;
        eng_valid_d = eng_valid_q;
        done_d      = 1'b0;
        err_d       = err_q;
        rem_next    = remaining_q - LEN_W'(beats_q);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    err_d = 1'b0;
                    if (bus.xfer_len != '0) begin
                        cur_addr_d  = bus.start_addr & ~ADDR_W'(BYTES - 1);
                        remaining_d = bus.xfer_len;
                        state_d     = CALC;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            CALC: begin
                beats_d    = beats_calc;
                eng_addr_d = cur_addr_q;
                eng_len_d  = 8'(beats_calc - 9'd1);
                popped_d   = '0;
                state_d    = FILL;
            end
            FILL: begin
                if (32'(count_q) >= 32'(beats_q)) begin
                    eng_valid_d = 1'b1;
                    state_d     = BURST;
                end
            end
            BURST: begin
                if (pop) begin
                    popped_d = popped_q + 9'd1;
                    // drop valid together with the last pop so it is never seen in RESP
                    if (popped_q + 9'd1 == beats_q) begin
                        eng_valid_d = 1'b0;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.eng_dma_ready) begin
                    err_d       = err_q | bus.eng_error;
                    remaining_d = rem_next;
                    cur_addr_d  = cur_addr_q + (ADDR_W'(beats_q) << BSH);
                    // an engine error abandons the rest; buffered words stay queued
                    if (rem_next == '0 || bus.eng_error) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.eng_valid = eng_valid_q;
    assign bus.eng_addr  = eng_addr_q;
    assign bus.eng_len   = eng_len_q;
    assign bus.eng_wdata = mem_q[rd_ptr_q];
    assign bus.eng_wstrb = '1;
endmodule

// File: tb/tb_dma_w_burst_ctrl.sv
// Bench for dma_w_burst_ctrl: table of transfer commands plus randomized
// transfers, checked against a burst-split model and a word-order scoreboard.
module tb_dma_w_burst_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dma_w_burst_ctrl_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) bus ();

    dma_w_burst_ctrl #(
        .ADDR_W(32), .DATA_W(32), .LEN_W(16), .MAX_BEATS(16), .FIFO_AW(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [31:0] a; logic [7:0] l; } burst_t;
    typedef struct {
        logic [31:0] addr; int len; int eb; bit pre; int mode;
        int exp_nb; logic [31:0] exp_a0; logic [7:0] exp_l0; bit exp_err;
    } vec_t;

    int n_cmp = 0, n_bad = 0;
    logic [31:0] src_q[$];     // words still to be offered by the source
    logic [31:0] exp_q[$];     // words accepted into the DUT, in order
    burst_t      obs_q[$];     // bursts seen on the engine port
    burst_t      mdl_q[$];     // bursts predicted by the model
    int src_mode = 0, ph = 0, push_total = 0;
    int err_burst = -1, burst_idx = 0;
    bit in_burst = 0;
    int beats_cnt = 0, resp_delay = -1, first_valid_pushes = -1;
    logic [31:0] cap_a;
    logic [7:0]  cap_l;
    bit prev_err = 0;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Split a transfer from the rules: <=16 beats, stop at each 4 KB page end.
    function automatic bit model(input logic [31:0] sa, input int len, input int eb);
        logic [31:0] a;
        int rem, room, b, idx;
        bit e;
        mdl_q.delete();
        e = 0; a = sa & ~32'h3; rem = len; idx = 0;
        while (rem > 0) begin
            room = (4096 - int'(a % 4096)) / 4;
            b = (rem > 16) ? 16 : rem;
            if (room < b) b = room;
            mdl_q.push_back('{a: a, l: 8'(b - 1)});
            if (idx == eb) begin e = 1; break; end
            a = a + 32'(b * 4);
            rem -= b;
            idx++;
        end
        return e;
    endfunction

    // Source: offers queued words with mode 0 = every cycle, 1 = 1-in-4, 2 = random
    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        forever begin
            @(negedge clk);
            if (rst && bus.s_valid && bus.s_ready) begin
                exp_q.push_back(bus.s_data);
                if (src_q.size() > 0) void'(src_q.pop_front());
                push_total++;
            end
            @(posedge clk);
            #1;
            ph++;
            if (src_q.size() > 0 && (src_mode == 0 || (src_mode == 1 && ph % 4 == 0) ||
                                     (src_mode == 2 && $urandom_range(0, 1) == 1))) begin
                bus.s_valid = 1'b1;
                bus.s_data  = src_q[0];
            end else begin
                bus.s_valid = 1'b0;
                bus.s_data  = $urandom;
            end
        end
    end

    // Engine: random ready, records bursts, checks word order, answers each burst
    initial begin
        bus.eng_ready     = 1'b0;
        bus.eng_dma_ready = 1'b0;
        bus.eng_error     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_burst = 0; resp_delay = -1; beats_cnt = 0;
            end else if (bus.eng_valid) begin
                if (!in_burst) begin
                    in_burst = 1; beats_cnt = 0;
                    cap_a = bus.eng_addr; cap_l = bus.eng_len;
                    obs_q.push_back('{a: bus.eng_addr, l: bus.eng_len});
                    if (first_valid_pushes < 0) first_valid_pushes = push_total;
                    chk("wstrb", bus.eng_wstrb, 4'hF);
                end else begin
                    chk("addr_stable", bus.eng_addr, cap_a);
                    chk("len_stable", bus.eng_len, cap_l);
                end
                if (bus.eng_ready) begin
                    chk("word_available", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("wdata", bus.eng_wdata, exp_q.pop_front());
                    beats_cnt++;
                end
            end else if (in_burst) begin
                in_burst = 0;
                chk("burst_beats", beats_cnt, cap_l + 1);
                resp_delay = $urandom_range(0, 3);
            end
            @(posedge clk);
            #1;
            bus.eng_ready = ($urandom_range(0, 3) != 0);
            if (in_burst) begin
                bus.eng_dma_ready = 1'b0;
                bus.eng_error     = 1'b0;
            end else if (resp_delay > 0) begin
                resp_delay--;
            end else if (resp_delay == 0) begin
                bus.eng_dma_ready = 1'b1;
                bus.eng_error     = (burst_idx == err_burst);
                burst_idx++;
                resp_delay = -1;
            end
        end
    end

    // One complete transfer: issue command, wait for done, compare bursts with model
    task automatic run_xfer(input logic [31:0] sa, input int len, input int eb,
                            input bit pre, input int mode);
        bit me;
        int k;
        me = model(sa, len, eb);
        chk("err_sticky", bus.err, prev_err);
        src_mode = mode; err_burst = eb; burst_idx = 0;
        obs_q.delete();
        for (int i = 0; i < len; i++) src_q.push_back($urandom);
        if (pre) begin
            for (int i = 0; i < 300 && src_q.size() > 0; i++) tick();
            tick();
            tick();
        end
        bus.start = 1'b1; bus.start_addr = sa; bus.xfer_len = 16'(len);
        tick();
        bus.start = 1'b0; bus.start_addr = $urandom; bus.xfer_len = 16'($urandom);
        chk("err_clr", bus.err, 0);
        k = 0;
        while (!bus.done && k < 3000) begin
            if (k == 0) chk("busy_run", bus.busy, 1);
            if (pre && k < 3) chk("start_to_valid", bus.eng_valid, k == 2);
            tick();
            k++;
        end
        chk("done_seen", bus.done, 1);
        if (len == 0) chk("zero_len_latency", k, 0);
        chk("busy_at_done", bus.busy, 0);
        chk("err", bus.err, me);
        tick();
        chk("done_1cyc", bus.done, 0);
        chk("nbursts", obs_q.size(), mdl_q.size());
        for (int i = 0; i < mdl_q.size() && i < obs_q.size(); i++) begin
            chk("burst_addr", obs_q[i].a, mdl_q[i].a);
            chk("burst_len", obs_q[i].l, mdl_q[i].l);
        end
        prev_err = me;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        src_q.delete();
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
        tick();
        prev_err = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        logic [31:0] sa;
        int len, eb, mode;

        tbl[0] = '{32'h1000,  4, -1, 1, 0, 1, 32'h1000, 8'd3,  0};
        tbl[1] = '{32'h0000, 40, -1, 0, 0, 3, 32'h0000, 8'd15, 0};
        tbl[2] = '{32'h0FF8,  6, -1, 1, 0, 2, 32'h0FF8, 8'd1,  0};
        tbl[3] = '{32'h0FC0, 40, -1, 0, 2, 3, 32'h0FC0, 8'd15, 0};
        tbl[4] = '{32'h0123,  5, -1, 1, 2, 1, 32'h0120, 8'd4,  0};
        tbl[5] = '{32'h0FFC,  1, -1, 1, 0, 1, 32'h0FFC, 8'd0,  0};
        tbl[6] = '{32'h0000, 40,  0, 0, 0, 1, 32'h0000, 8'd15, 1};
        tbl[7] = '{32'h0000,  0, -1, 0, 0, 0, 32'h0000, 8'd0,  0};

        bus.start = 1'b0; bus.start_addr = '0; bus.xfer_len = '0;
        repeat (3) tick();
        chk("rst_eng_valid", bus.eng_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_eng_addr", bus.eng_addr, 0);
        chk("rst_eng_len", bus.eng_len, 0);
        rst = 1'b1;
        #1;
        chk("s_ready_release", bus.s_ready, 0);
        tick();
        chk("s_ready_rise", bus.s_ready, 1);

        for (int r = 0; r < 8; r++) begin
            run_xfer(tbl[r].addr, tbl[r].len, tbl[r].eb, tbl[r].pre, tbl[r].mode);
            chk("tbl_nbursts", obs_q.size(), tbl[r].exp_nb);
            chk("tbl_err", bus.err, tbl[r].exp_err);
            if (obs_q.size() > 0 && tbl[r].exp_nb > 0) begin
                chk("tbl_addr0", obs_q[0].a, tbl[r].exp_a0);
                chk("tbl_len0", obs_q[0].l, tbl[r].exp_l0);
            end
            repeat (3) tick();
        end

        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 1)
                sa = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 1023)) << 2);
            else
                sa = (32'($urandom_range(1, 4)) << 12) - (32'($urandom_range(1, 24)) << 2);
            sa = sa | 32'($urandom_range(0, 3));
            len  = $urandom_range(1, 70);
            eb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            mode = $urandom_range(0, 2);
            run_xfer(sa, len, eb, 0, mode);
            repeat (2) tick();
        end

        // slow source: burst must wait for 16 buffered words; then reset mid-burst
        do_reset();
        push_total = 0; first_valid_pushes = -1;
        src_mode = 1; err_burst = -1; burst_idx = 0;
        obs_q.delete();
        for (int i = 0; i < 20; i++) src_q.push_back($urandom);
        bus.start = 1'b1; bus.start_addr = 32'h200; bus.xfer_len = 16'd20;
        tick();
        bus.start = 1'b0;
        k = 0;
        while (!(in_burst && beats_cnt >= 3) && k < 1000) begin
            tick();
            k++;
        end
        chk("midburst_reached", in_burst && beats_cnt >= 3, 1);
        chk("fill_before_valid", first_valid_pushes >= 16, 1);
        chk("slow_first_len", obs_q.size() > 0 ? obs_q[0].l : 8'hFF, 8'd15);
        rst = 1'b0;
        #1;
        chk("mid_rst_eng_valid", bus.eng_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_err", bus.err, 0);
        chk("mid_rst_s_ready", bus.s_ready, 0);
        chk("mid_rst_eng_addr", bus.eng_addr, 0);
        chk("mid_rst_eng_len", bus.eng_len, 0);
        src_q.delete();
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("s_ready_release2", bus.s_ready, 0);
        tick();
        chk("s_ready_rise2", bus.s_ready, 1);
        prev_err = 0;
        // only fresh words may come out if the FIFO was flushed
        run_xfer(32'h40, 3, -1, 1, 0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dma_w_burst_ctrl.md
# dma_w_burst_ctrl

Write-side burst controller that sits directly upstream of the DMA AXI write engine. Accepts a transfer command (start byte address, word count) and a word stream, and buffers the words in an internal FIFO. It splits the transfer into INCR bursts of at most MAX_BEATS beats that never cross a 4 KB boundary. Each burst is presented to the engine's databus/config port only once all its data is buffered.

## Interface
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; power of 2, ≥ 8.
- LEN_W, 16, transfer word-count width.
- MAX_BEATS, 16, max beats per burst; power of 2, ≤ 256.
- FIFO_AW, 5, FIFO address width; 2^FIFO_AW ≥ MAX_BEATS.

Ports:
- Clock and reset (already decided): one clock `clk`; reset `rst` is asynchronous and active-low.
- clk  in  1  clock.
- rst  in  1  async active-low reset.
- start  in  1  command pulse; sampled only in IDLE.
- start_addr  in  ADDR_W  byte address; low log2(DATA_W/8) bits are forced to 0.
- xfer_len  in  LEN_W  number of words to transfer.
- busy  out  1  high whenever not in IDLE.
- done  out  1  one-cycle pulse at end of transfer.
- err  out  1  sticky error; cleared by the next accepted start.
- s_valid  in  1  source word valid.
- s_data  in  DATA_W  source word.
- s_ready  out  1  FIFO not full.
- eng_valid  out  1  engine databus valid.
- eng_addr  out  ADDR_W  burst start address.
- eng_wdata  out  DATA_W  FIFO head word (show-ahead).
- eng_wstrb  out  DATA_W/8  all ones.
- eng_len  out  8  beats−1 (AXI len encoding).
- eng_ready  in  1  engine consumed the current word.
- eng_dma_ready  in  1  engine idle, ready for the next burst.
- eng_error  in  1  engine's error of the last response.

## Operation
- FIFO: depth 2^FIFO_AW, show-ahead; push when s_valid & s_ready; pop when eng_ready in BURST.
  - Push accepted in any state, including IDLE.
  - Simultaneous push and pop leaves count unchanged.
- Registers: cur_addr, remaining (LEN_W), beats (9 bits), popped (9 bits).
- States:
  - IDLE: on start with xfer_len≠0 → load cur_addr and remaining, clear err, → CALC. On start with xfer_len=0 → clear err, pulse done next cycle, stay IDLE.
  - CALC (1 cycle): beats = min(remaining, MAX_BEATS, (4096 − cur_addr[11:0])/(DATA_W/8)). Latch eng_addr=cur_addr and eng_len=beats−1. → FILL.
  - FILL: wait until fifo_count ≥ beats. → BURST.
  - BURST: eng_valid=1 with eng_addr/eng_len stable. Count pops. On the cycle popped reaches beats, eng_valid is registered low for the next cycle. → RESP.
  - RESP: wait for eng_dma_ready=1, then:
    - err |= eng_error;
    - remaining −= beats;
    - cur_addr += beats·DATA_W/8.
    - If remaining=0 or eng_error → IDLE with done pulse. Else → CALC.
- Error aborts the remaining bursts. Words already buffered stay in the FIFO.
- eng_ready outside BURST is ignored; nothing is popped.

## Timing
- Reset values:
  - eng_valid, busy, done, err, s_ready = 0. s_ready rises the first cycle after reset release.
  - eng_addr, eng_len = 0.
  - FIFO empty; state IDLE.
- start → eng_valid: minimum 2 cycles (IDLE→CALC→FILL→BURST) when data is already buffered.
- eng_valid goes low the cycle after the last pop. It must never be high in RESP, so the engine cannot restart.
- done asserts the cycle after RESP exits to IDLE, for exactly 1 cycle.
- Reset mid-burst: immediate return to IDLE, FIFO flushed, all outputs take reset values.
- FIFO full: s_ready=0. FIFO empty during BURST is impossible, because FILL guarantees the data is present.

## Test plan
- start_addr=0x1000, xfer_len=4, words preloaded → one burst: eng_addr=0x1000, eng_len=3, 4 pops, done, err=0.
- start_addr=0x0, xfer_len=40, MAX_BEATS=16 → bursts at 0x00/0x40/0x80 with eng_len 15/15/7; data order preserved.
- start_addr=0xFF8, xfer_len=6 → bursts (0xFF8, len 1) then (0x1000, len 3); neither crosses 4 KB.
- xfer_len=0 → done 1 cycle later; eng_valid never asserts.
- eng_error=1 on the first of 3 bursts → no further eng_valid, done pulse, err=1; err cleared by the next start.
- s_valid toggling 1-in-4 with xfer_len=20 → first eng_valid only after 16 words are buffered; assert rst mid-burst → eng_valid=0, FIFO empty, busy=0.
